// File: rtl/imem_pkg.sv
// ----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory arbiter and the IF stage.
//   arb_state_t      : arbiter FSM states (BOOT while loading, RUN afterwards)
//   PC_BASE_DEFAULT  : byte address mapped to word 0 of the instruction memory;
//                      the IF stage also uses it as its reset PC
//   NOP_WORD         : instruction returned for fetches that cannot be served
//   word_offset()    : byte address -> word offset from a base address
// ----------------------------------------------------------------------------
package imem_pkg;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } arb_state_t;

   localparam logic [31:0] PC_BASE_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] NOP_WORD        = 32'h0000_0000;

   // Word offset of a byte address relative to a base. The subtraction wraps
   // modulo 2^32, so addresses below the base land at the top of the space;
   // callers truncate to the memory's index width to get wrap-around.
   function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                               input logic [31:0] base);
      return (addr - base) >> 2;
   endfunction

endpackage

// File: rtl/imem_addr_map.sv
// ----------------------------------------------------------------------------
// imem_addr_map
// Combinational byte-address to RAM word-index translation, plus a flag that
// reports whether the address falls outside the mapped window.
// Parameters:
//   ADDR_W  : word-index width of the memory (2^ADDR_W words)
//   PC_BASE : byte address mapped to word 0
// Ports:
//   addr         in  32      byte address to translate
//   index        out ADDR_W  RAM word index, wraps modulo the memory size
//   out_of_range out 1       below PC_BASE, past the end of the memory, or
//                            not word aligned
// ----------------------------------------------------------------------------
module imem_addr_map
   import imem_pkg::*;
#(
   parameter int          ADDR_W  = 12,
   parameter logic [31:0] PC_BASE = PC_BASE_DEFAULT
) (
   input  logic [31:0]       addr,
   output logic [ADDR_W-1:0] index,
   output logic              out_of_range
);

   // Size of the mapped window in bytes. One bit wider than an address so the
   // comparison stays exact even when the window covers most of the space.
   localparam logic [32:0] SPAN_BYTES = 33'd1 << (ADDR_W + 2);

   logic [31:0] byte_off;

   // The index keeps only the low bits of the word offset, which gives the
   // modulo-memory-size wrap. The range flag looks at the full offset instead:
   // an address below the base wraps to a huge offset, so the explicit
   // "addr < PC_BASE" test is kept for clarity even though the span test
   // would also catch it.
   always_comb begin
      byte_off     = addr - PC_BASE;
      index        = ADDR_W'(word_offset(addr, PC_BASE));
      out_of_range = (addr < PC_BASE)
                  || ({1'b0, byte_off} >= SPAN_BYTES)
                  || (addr[1:0] != 2'b00);
   end

endmodule

// File: rtl/imem_arbiter.sv
// ----------------------------------------------------------------------------
// imem_arbiter
// Owns the single port of the synchronous-read instruction RAM and shares it
// between the CPU fetch stage and the program loader. After reset the CPU is
// stalled while the loader fills memory (BOOT). Once the loader raises ld_done
// fetches are served (RUN); late loader writes still get in, but the loader
// can win at most MAX_LD_BURST consecutive contested cycles before a fetch is
// forced through.
//
// Optional feature macro: IMEM_ARB_RANGE_CHECK_EN
//   defined   : out-of-range fetches return NOP_WORD, out-of-range writes are
//               handshaked but not written, addr_err pulses for one cycle
//   undefined : addresses wrap modulo the memory size, addr_err is 0
//
// Parameters:
//   ADDR_W       : word-index width of the memory (2^ADDR_W words)
//   PC_BASE      : byte address mapped to word 0
//   MAX_LD_BURST : max consecutive contested cycles the loader may win (>= 1)
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   fetch_req, fetch_pc     fetch request and its byte address
//   fetch_valid, fetch_instr registered fetch response (one cycle after grant)
//   cpu_stall               freezes PC and IF/ID when a fetch cannot proceed
//   ld_valid, ld_addr, ld_data, ld_ready   loader write handshake
//   ld_done                 loader finished the program image
//   addr_err                dropped / out-of-range access indication
//   mem_addr, mem_we, mem_wdata, mem_rdata RAM port (write-first, 1-cycle read)
// ----------------------------------------------------------------------------
module imem_arbiter
   import imem_pkg::*;
#(
   parameter int          ADDR_W       = 12,
   parameter logic [31:0] PC_BASE      = PC_BASE_DEFAULT,
   parameter int          MAX_LD_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              fetch_req,
   input  logic [31:0]       fetch_pc,
   output logic              fetch_valid,
   output logic [31:0]       fetch_instr,
   output logic              cpu_stall,

   input  logic              ld_valid,
   input  logic [31:0]       ld_addr,
   input  logic [31:0]       ld_data,
   output logic              ld_ready,
   input  logic              ld_done,

   output logic              addr_err,

   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int              CNT_W       = $clog2(MAX_LD_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_LD_BURST);

   arb_state_t        state;
   arb_state_t        state_next;
   logic [CNT_W-1:0]  burst_cnt;

   logic              contested;
   logic              fetch_grant;
   logic              ld_grant;

   logic [ADDR_W-1:0] fetch_idx;
   logic [ADDR_W-1:0] ld_idx;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              fetch_oor_raw;
   logic              ld_oor_raw;
   logic              fetch_bad;
   logic              ld_bad;
   logic              fetch_bad_q;
   logic [31:0]       instr_hold;

   // Two identical translators so both requesters' indices and range flags
   // are ready before arbitration picks one of them.
   imem_addr_map #(
      .ADDR_W  (ADDR_W),
      .PC_BASE (PC_BASE)
   ) u_fetch_map (
      .addr         (fetch_pc),
      .index        (fetch_idx),
      .out_of_range (fetch_oor_raw)
   );

   imem_addr_map #(
      .ADDR_W  (ADDR_W),
      .PC_BASE (PC_BASE)
   ) u_ld_map (
      .addr         (ld_addr),
      .index        (ld_idx),
      .out_of_range (ld_oor_raw)
   );

   // With range checking the translator flags decide whether an access is
   // suppressed; without it every access is legal and simply wraps.
`ifdef IMEM_ARB_RANGE_CHECK_EN
   assign fetch_bad = fetch_oor_raw;
   assign ld_bad    = ld_oor_raw;
   assign addr_err  = fetch_bad_q | (ld_grant & ld_bad);
`else
   logic unused_range_flags;
   assign unused_range_flags = fetch_oor_raw | ld_oor_raw;
   assign fetch_bad = 1'b0;
   assign ld_bad    = 1'b0;
   assign addr_err  = 1'b0;
`endif

   // FSM state register. BOOT waits for the loader; RUN serves fetches.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= BOOT;
      end else begin
         state <= state_next;
      end
   end

   // Next state and arbitration. While reset is held nothing is granted and
   // the CPU stays stalled. In BOOT the loader owns the port outright and
   // ld_ready is high even without a request; a write in the ld_done cycle is
   // still performed. In RUN a contested cycle goes to the loader until it has
   // won MAX_LD_BURST in a row, then one fetch is forced through.
   always_comb begin
      state_next  = state;
      contested   = fetch_req & ld_valid;
      fetch_grant = 1'b0;
      ld_grant    = 1'b0;
      ld_ready    = 1'b0;
      cpu_stall   = 1'b1;
      if (!reset) begin
         case (state)
            BOOT: begin
               ld_ready = 1'b1;
               ld_grant = ld_valid;
               if (ld_done) begin
                  state_next = RUN;
               end
            end
            RUN: begin
               if (contested) begin
                  if (burst_cnt == BURST_LIMIT) begin
                     fetch_grant = 1'b1;
                  end else begin
                     ld_grant = 1'b1;
                  end
               end else begin
                  fetch_grant = fetch_req;
                  ld_grant    = ld_valid;
               end
               ld_ready  = ld_grant;
               cpu_stall = fetch_req & ~fetch_grant;
            end
            default: begin
               state_next = BOOT;
            end
         endcase
      end
   end

   // RAM port steering. An idle cycle keeps the last address on the bus so the
   // RAM is not toggled needlessly. A suppressed out-of-range write still
   // drives the address but keeps the write enable low.
   always_comb begin
      mem_addr  = mem_addr_q;
      mem_we    = 1'b0;
      mem_wdata = ld_data;
      if (fetch_grant) begin
         mem_addr = fetch_idx;
      end else if (ld_grant) begin
         mem_addr = ld_idx;
         mem_we   = ~ld_bad;
      end
   end

   // Consecutive contested loader wins. Any fetch grant resets the run, and
   // uncontested loader writes do not count against the fetch stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         burst_cnt <= '0;
      end else if (fetch_grant) begin
         burst_cnt <= '0;
      end else if (ld_grant && contested && (state == RUN)) begin
         burst_cnt <= burst_cnt + CNT_W'(1);
      end
   end

   // Response pipeline: the RAM returns data one cycle after the address, so
   // the grant and its range flag are delayed by one cycle to line up with it.
   // The idle address is also remembered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_valid <= 1'b0;
         fetch_bad_q <= 1'b0;
         instr_hold  <= NOP_WORD;
         mem_addr_q  <= '0;
      end else begin
         fetch_valid <= fetch_grant;
         fetch_bad_q <= fetch_grant & fetch_bad;
         instr_hold  <= fetch_instr;
         mem_addr_q  <= mem_addr;
      end
   end

   // The instruction output follows the RAM in a response cycle and otherwise
   // repeats the last delivered word, so a stalled IF/ID sees stable data.
   always_comb begin
      if (fetch_valid) begin
         fetch_instr = fetch_bad_q ? NOP_WORD : mem_rdata;
      end else begin
         fetch_instr = instr_hold;
      end
   end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Owns the single port of the instruction memory and shares it between the CPU fetch stage and the program loader. After reset it holds the CPU in stall while the loader fills the memory. Once the loader signals completion it serves fetches, still accepting late loader writes under a bounded-priority rule. It sits between the IF stage/PC register and the instruction-memory array. The array is a synchronous-read RAM.

## Interface
Parameters:
- `ADDR_W`, default 12: word-index width of the memory (2^ADDR_W words).
- `PC_BASE`, default 32'h0000_3000: byte address mapped to word 0.
- `MAX_LD_BURST`, default 4: maximum consecutive contested cycles the loader may win.

Ports:
- `clk` in 1: sole clock. All registers update on the rising edge.
- `reset` in 1: synchronous, active-high.
- `fetch_req` in 1: the fetch stage requests the instruction at `fetch_pc`.
- `fetch_pc` in 32: byte address of the fetch.
- `fetch_valid` out 1: `fetch_instr` holds a completed fetch this cycle.
- `fetch_instr` out 32: the fetched instruction word.
- `cpu_stall` out 1: freezes the PC and the IF/ID register.
- `ld_valid` in 1: the loader presents a write.
- `ld_addr` in 32: byte address of the write.
- `ld_data` in 32: word to write.
- `ld_ready` out 1: the write is accepted this cycle when `ld_valid` is also high.
- `ld_done` in 1: the loader has finished the program image.
- `addr_err` out 1: a dropped or out-of-range access occurred (see Configuration).
- `mem_addr` out ADDR_W: RAM word index.
- `mem_we` out 1: RAM write enable.
- `mem_wdata` out 32: RAM write data.
- `mem_rdata` in 32: RAM read data, valid one cycle after the address is presented.

## Operation
- FSM states:
  - BOOT, entered on reset.
  - RUN.
- BOOT behaviour:
  - `cpu_stall`=1 and `fetch_req` is ignored.
  - `ld_ready`=1, so every `ld_valid` cycle performs a write.
  - On `ld_done`=1: go to RUN next cycle.
  - A write presented in the same cycle as `ld_done` is still performed.
- RUN behaviour:
  - Transfers:
    - Fetch grant: `mem_addr`=index(`fetch_pc`), `mem_we`=0.
    - Loader grant: `mem_addr`=index(`ld_addr`), `mem_we`=1, `mem_wdata`=`ld_data`, `ld_ready`=1.
  - Uncontested: whichever of `fetch_req` or `ld_valid` is high is granted.
  - Contested (both high):
    - The loader wins unless `burst_cnt`==MAX_LD_BURST.
    - If the loader wins, `burst_cnt` increments.
    - If `burst_cnt`==MAX_LD_BURST, fetch wins and `ld_ready`=0.
  - `burst_cnt` clears on any fetch grant.
  - `cpu_stall`=1 in any cycle where `fetch_req`=1 but fetch is not granted.
  - `ld_done` has no effect.
- Index computation: index = (addr − PC_BASE)[ADDR_W+1:2]. Bits [1:0] are ignored.
- Fetch response is registered:
  - `fetch_valid` = registered fetch grant.
  - `fetch_instr` = `mem_rdata` when `fetch_valid`, else holds its previous value.
- When neither requester is granted: `mem_we`=0 and `mem_addr` holds its previous value.

## Timing
- Reset values:
  - State=BOOT.
  - `fetch_valid`=0.
  - `fetch_instr`=0.
  - `burst_cnt`=0.
  - `addr_err`=0.
  - `cpu_stall`=1.
  - `mem_we`=0.
- While `reset`=1, `ld_ready`=0 and no write occurs.
- Fetch latency: a grant in cycle N gives `fetch_valid`=1 with the data in cycle N+1.
- Back-to-back fetches sustain one word per cycle.
- Write latency: 0. Data is in the RAM at the edge that ends the accept cycle.
- Read-after-write to the same word in consecutive cycles returns the new data (RAM is write-first).
- Reset asserted mid-RUN:
  - Returns to BOOT next edge.
  - Any pending `fetch_valid` is dropped.
  - `burst_cnt` clears.

## Configuration
- Macro: `IMEM_ARB_RANGE_CHECK_EN`.
- Defined:
  - An access is out of range if addr<PC_BASE, or addr−PC_BASE ≥ 4·2^ADDR_W, or addr[1:0]≠0.
  - Out-of-range fetch: granted normally, but `fetch_instr`=32'h0000_0000 (nop).
  - Out-of-range write: handshaked (`ld_ready`=1) with `mem_we`=0.
  - `addr_err` pulses for one cycle, aligned with the response cycle for a fetch and with the accept cycle for a write.
- Undefined:
  - Addresses wrap modulo the memory size.
  - `addr_err` is tied to 0.

## Structure
- Shared package `imem_pkg`:
  - FSM state enum (BOOT, RUN).
  - `PC_BASE_DEFAULT`.
  - `NOP_WORD`.
  - An index-computation function.
- The IF stage uses the same package for its reset PC.
- One sub-module: `imem_addr_map`, combinational. It computes the index and the range flag, and is instantiated twice (fetch and loader).
- The FSM, arbiter and response register live in the top module.
- The RAM array is external.

## Test plan
- Boot load: reset, then write 0x3000←0x2408_0005 and 0x3004←0x2409_0007, with `ld_done` on the second write. Expect:
  - `cpu_stall`=1 throughout BOOT.
  - RUN the next cycle.
  - Fetch 0x3000 and then 0x3004 returns those words with 1-cycle latency, back-to-back.
- Contention with MAX_LD_BURST=4: hold `fetch_req` and `ld_valid` high for 10 cycles. Expect the loader granted 4 cycles, fetch 1, loader 4, fetch 1. `ld_ready`=0 in the fetch cycles.
- Read-after-write: in RUN, write 0x3008←0xDEAD_BEEF, then fetch 0x3008 next cycle. Expect `fetch_instr`=0xDEAD_BEEF.
- Range check (macro defined): fetch 0x2FFC. Expect `fetch_instr`=0 and `addr_err`=1 in the response cycle. A write to 0x7000 is accepted with `mem_we`=0.
- Wrap (macro undefined): a write to 0x7000 lands at index 0. `addr_err` stays 0.
- Mid-run reset: assert `reset` during a fetch grant. Expect:
  - Next cycle `fetch_valid`=0 and `cpu_stall`=1.
  - The FSM is in BOOT.
  - Fetches are ignored until `ld_done`.
